uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the single `uart_tx` byte channel between `NUM_REQ` on-chip requesters. It sits between the requesters and `uart_tx` in the `chip` top level. It grants one requester at a time and forwards that requester's valid/ready byte stream to the transmitter. Optionally it holds the grant for a whole multi-byte message so that messages from different requesters are never interleaved on `UART_TX`.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; legal range 1..16.
- `DATA_W`, default 8: byte width of each requester channel and of the transmitter channel.

Ports:
- `clk`  in  1: system clock (100 MHz).
- `rst`  in  1: reset; asynchronous assert, active-low.
- `req_valid`  in  NUM_REQ: per-requester byte valid.
- `req_data`  in  NUM_REQ*DATA_W: per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W].
- `req_last`  in  NUM_REQ: marks the final byte of a message; used only with packet lock.
- `req_ready`  out  NUM_REQ: per-requester byte accepted.
- `tx_data`  out  DATA_W: byte to `uart_tx`.
- `tx_valid`  out  1: byte valid to `uart_tx`.
- `tx_ready`  in  1: `uart_tx` can accept a byte.
- `grant`  out  NUM_REQ: one-hot current owner; all-zero when idle.
- `busy`  out  1: high whenever `grant` is non-zero.

## Operation
- FSM with two states, IDLE and OWN.
- **IDLE**
  - `grant` = 0.
  - If any `req_valid` bit is high, select a winner by round-robin. The search starts at index `ptr+1` (mod NUM_REQ) and takes the first valid requester.
  - Register the winner into `grant` and move to OWN.
- **OWN** (owner g):
  - `tx_valid` = `req_valid[g]` and `tx_data` = slice g of `req_data`. Both are combinational passthrough of the owner.
  - `req_ready[g]` = `tx_ready`. Every other `req_ready` bit is 0.
- **Handshake**: a handshake occurs when `tx_valid && tx_ready`.
  - Without packet lock: on a handshake, set `ptr`←g, clear `grant`, return to IDLE.
  - With packet lock: on a handshake with `req_last[g]`=1, release as above. On a handshake with `req_last[g]`=0, stay in OWN.
- **Requester rule**: once `req_valid` is asserted, data must be held stable until the handshake.
  - If the owner drops `req_valid` while in OWN without a handshake, the arbiter keeps the grant and `tx_valid` falls. The channel stalls; this is legal, and no timeout is applied.
- **Non-owners** never see `req_ready`=1, whatever they drive.
- **NUM_REQ=1**: the block degenerates to one cycle of grant latency per byte (per message with packet lock).

## Timing
- **Reset values** (asynchronous, while `rst`=0):
  - State IDLE, `grant`=0, `busy`=0, `tx_valid`=0, `req_ready`=0, `tx_data`=0.
  - `ptr`=NUM_REQ-1, so requester 0 has first priority after reset.
- **Arbitration latency**: `req_valid` high in cycle N (state IDLE) gives `grant`/`busy` high and `tx_valid` high in cycle N+1.
- **Release**: the handshake in cycle M is followed by IDLE in M+1 and a new grant visible in M+2. Peak throughput is therefore one byte per 2 cycles, which is negligible against the UART bit time.
- **Simultaneous requests**: the winner follows strict rotation from `ptr`. With all requesters valid and no lock, the grant order is 0,1,2,3,0,...
- **Reset mid-byte**: all outputs clear immediately, the byte in flight is not acknowledged, and the FSM returns to IDLE.

## Configuration
- Macro: `UART_TX_ARB_PACKET_LOCK_EN`.
- **Defined**: the grant is held until a handshake with `req_last` high. A message of k bytes is sent contiguously.
- **Undefined**: re-arbitration happens after every byte. `req_last` is ignored and may be left unconnected (tie to 0).

## Structure
- **Package `uart_arb_pkg`**:
  - `typedef enum logic [0:0] {ARB_IDLE, ARB_OWN} arb_state_t`.
  - `localparam int ARB_MAX_REQ = 16`.
  - Function `onehot_to_idx`.
- **Sub-module `rr_picker`**:
  - Purely combinational.
  - Inputs: request vector and `ptr`.
  - Outputs: one-hot winner and `any`.
  - Instantiated once.
- The top level holds the FSM, the grant/`ptr` registers and the output muxing; no other sub-modules.

## Test plan
- **Reset and first grant**: hold `rst`=0; check all outputs are 0. Release reset; requester 2 presents 0x41 with `tx_ready`=1. Expect `grant`=4'b0100 one cycle later, `tx_data`=0x41, `tx_valid`=1, and the `req_ready[2]` pulse.
- **Round-robin fairness**: all 4 requesters continuously valid with bytes 0x10..0x13, `tx_ready`=1, no lock. Expect the byte sequence 0x10,0x11,0x12,0x13,0x10.
- **Backpressure**: hold `tx_ready`=0 for 20 cycles while requester 1 is owner. Expect `tx_valid` held high, `tx_data` stable, `req_ready`=0, and no grant change.
- **Packet lock** (macro defined): requester 0 sends 3 bytes (last on byte 3) while requester 1 is also valid. Expect all of requester 0's bytes before any of requester 1's. With the macro undefined, expect the bytes alternate.
- **Reset mid-operation**: assert `rst`=0 while owner 3 waits on `tx_ready`. Expect `tx_valid`, `grant` and `req_ready` to clear without a clock edge. After release, requester 0 wins first.
- **Owner stall**: the owner drops `req_valid` before its handshake. Expect `grant` held, `tx_valid`=0, and other requesters blocked until the owner re-asserts and completes.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and helpers for the uart_tx round-robin arbiter
package uart_arb_pkg;

  typedef enum logic [0:0] {ARB_IDLE, ARB_OWN} arb_state_t;

  localparam int ARB_MAX_REQ = 16;
  localparam int ARB_IDX_W   = 4;

  // Assumes a one-hot (or zero) input; zero maps to index 0.
  function automatic logic [ARB_IDX_W-1:0] onehot_to_idx(input logic [ARB_MAX_REQ-1:0] oh);
    logic [ARB_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_MAX_REQ; i++) begin
      if (oh[i]) idx = idx | ARB_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner select starting after ptr
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win,
  output logic               any
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // Scan ptr+1 .. ptr+NUM_REQ (mod NUM_REQ); the last slot visited is ptr itself.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin share of the uart_tx byte channel
// Optional whole-message grant hold: UART_TX_ARB_PACKET_LOCK_EN
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;

  logic [NUM_REQ-1:0] win;
  logic               any_req;
  logic [PTR_W-1:0]   own_idx;
  logic               handshake;
  logic               release_grant;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req (req_valid),
    .ptr (ptr_q),
    .win (win),
    .any (any_req)
  );

  assign own_idx   = PTR_W'(onehot_to_idx(ARB_MAX_REQ'(grant_q)));
  assign handshake = tx_valid && tx_ready;

`ifdef UART_TX_ARB_PACKET_LOCK_EN
  assign release_grant = handshake && req_last[own_idx];
`else
  logic unused_req_last;
  assign unused_req_last = ^req_last;
  assign release_grant   = handshake;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          grant_d = win;
          state_d = ARB_OWN;
        end
      end
      ARB_OWN: begin
        if (release_grant) begin
          ptr_d   = own_idx;
          grant_d = '0;
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Owner channel is a combinational passthrough; non-owners are never readied.
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    if (state_q == ARB_OWN) begin
      tx_valid  = req_valid[own_idx];
      tx_data   = req_data[int'(own_idx)*DATA_W +: DATA_W];
      req_ready = grant_q & {NUM_REQ{tx_ready}};
    end
  end

  assign grant = grant_q;
  assign busy  = |grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  grant;
  logic        busy;

  int vectors;
  int errors;

  logic [7:0] src_data [4][8];
  logic       src_lastf[4][8];
  int         src_len[4];
  int         src_pos[4];
  logic [7:0] obs[$];

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .grant     (grant),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0; req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic clear_sources();
    for (int i = 0; i < 4; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
      for (int j = 0; j < 8; j++) begin
        src_data[i][j]  = '0;
        src_lastf[i][j] = 1'b0;
      end
    end
  endtask

  task automatic drive_sources();
    for (int i = 0; i < 4; i++) begin
      if (src_pos[i] < src_len[i]) begin
        req_valid[i]       = 1'b1;
        req_data[i*8 +: 8] = src_data[i][src_pos[i]];
        req_last[i]        = src_lastf[i][src_pos[i]];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  task automatic run_sources(input int max_cycles);
    logic [3:0] hs;
    bit done;
    obs.delete();
    tx_ready = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      drive_sources();
      #1;
      if (tx_valid && tx_ready) obs.push_back(tx_data);
      hs = req_valid & req_ready;
      tick();
      done = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (hs[i]) src_pos[i]++;
        if (src_pos[i] < src_len[i]) done = 1'b0;
      end
      if (done) break;
    end
    drive_sources();
    tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 4'b0100; req_data = '0; req_data[23:16] = 8'h41;
    req_last = 4'b0100; tx_ready = 1'b1;
    tick();
    #1;
    vectors++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_grant got=%b exp=0000", grant); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    vectors++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); end
    vectors++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready got=%b exp=0000", req_ready); end
    vectors++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
    rst = 1'b1;
    #1;
    vectors++; if (grant !== 4'b0000) begin errors++; $display("FAIL idle_grant got=%b exp=0000", grant); end
    tick();
    #1;
    vectors++; if (grant !== 4'b0100) begin errors++; $display("FAIL first_grant got=%b exp=0100", grant); end
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL first_busy got=%b exp=1", busy); end
    vectors++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL first_tx_valid got=%b exp=1", tx_valid); end
    vectors++; if (tx_data !== 8'h41) begin errors++; $display("FAIL first_tx_data got=%h exp=41", tx_data); end
    vectors++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL first_req_ready got=%b exp=0100", req_ready); end
    tick();
    req_valid = '0;
    #1;
    vectors++; if (grant !== 4'b0000) begin errors++; $display("FAIL release_grant got=%b exp=0000", grant); end
    vectors++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL release_ready got=%b exp=0000", req_ready); end
    tick();
    vectors++; if (grant !== 4'b0000) begin errors++; $display("FAIL no_regrant got=%b exp=0000", grant); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp;
    do_reset();
    clear_sources();
    for (int i = 0; i < 4; i++) begin
      src_len[i] = 2;
      for (int j = 0; j < 2; j++) begin
        src_data[i][j]  = 8'h10 + 8'(i);
        src_lastf[i][j] = 1'b1;
      end
    end
    run_sources(60);
    vectors++; if (obs.size() != 8) begin errors++; $display("FAIL rr_count got=%0d exp=8", obs.size()); end
    for (int k = 0; k < 8; k++) begin
      exp = 8'h10 + 8'(k % 4);
      vectors++;
      if (k >= obs.size()) begin errors++; $display("FAIL rr_byte%0d got=none exp=%h", k, exp); end
      else if (obs[k] !== exp) begin errors++; $display("FAIL rr_byte%0d got=%h exp=%h", k, obs[k], exp); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b0010; req_data[15:8] = 8'h55; req_data[7:0] = 8'h99; tx_ready = 1'b0;
    tick();
    #1;
    vectors++; if (grant !== 4'b0010) begin errors++; $display("FAIL bp_grant got=%b exp=0010", grant); end
    req_valid = 4'b0011;
    for (int c = 0; c < 20; c++) begin
      tick();
      #1;
      vectors++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d got=%b exp=1", c, tx_valid); end
      vectors++; if (tx_data !== 8'h55) begin errors++; $display("FAIL bp_data c%0d got=%h exp=55", c, tx_data); end
      vectors++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready c%0d got=%b exp=0000", c, req_ready); end
      vectors++; if (grant !== 4'b0010) begin errors++; $display("FAIL bp_hold c%0d got=%b exp=0010", c, grant); end
    end
    tx_ready = 1'b1;
    #1;
    vectors++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_accept got=%b exp=0010", req_ready); end
    tick();
    req_valid = 4'b0001;
    #1;
    vectors++; if (grant !== 4'b0000) begin errors++; $display("FAIL bp_idle got=%b exp=0000", grant); end
    tick();
    #1;
    vectors++; if (grant !== 4'b0001) begin errors++; $display("FAIL bp_next_grant got=%b exp=0001", grant); end
    vectors++; if (tx_data !== 8'h99) begin errors++; $display("FAIL bp_next_data got=%h exp=99", tx_data); end
    tick();
    req_valid = '0; tx_ready = 1'b0;
    tick();
  endtask

  task automatic test_packet_lock();
    logic [7:0] exp_seq[6];
    do_reset();
    clear_sources();
    src_len[0] = 3; src_len[1] = 3;
    for (int j = 0; j < 3; j++) begin
      src_data[0][j]  = 8'hA0 + 8'(j);
      src_data[1][j]  = 8'hB0 + 8'(j);
      src_lastf[0][j] = (j == 2);
      src_lastf[1][j] = 1'b1;
    end
`ifdef UART_TX_ARB_PACKET_LOCK_EN
    exp_seq = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2};
`else
    exp_seq = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2};
`endif
    run_sources(60);
    vectors++; if (obs.size() != 6) begin errors++; $display("FAIL lock_count got=%0d exp=6", obs.size()); end
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (k >= obs.size()) begin errors++; $display("FAIL lock_byte%0d got=none exp=%h", k, exp_seq[k]); end
      else if (obs[k] !== exp_seq[k]) begin errors++; $display("FAIL lock_byte%0d got=%h exp=%h", k, obs[k], exp_seq[k]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b1000; req_data = '0; req_data[31:24] = 8'h33; req_data[7:0] = 8'h99;
    req_last = 4'b1001; tx_ready = 1'b0;
    tick();
    #1;
    vectors++; if (grant !== 4'b1000) begin errors++; $display("FAIL mid_grant got=%b exp=1000", grant); end
    req_valid = 4'b1001;
    #1;
    rst = 1'b0;
    #1;
    vectors++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_tx_valid got=%b exp=0", tx_valid); end
    vectors++; if (grant !== 4'b0000) begin errors++; $display("FAIL mid_grant_clr got=%b exp=0000", grant); end
    vectors++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready got=%b exp=0000", req_ready); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", busy); end
    vectors++; if (tx_data !== 8'h00) begin errors++; $display("FAIL mid_tx_data got=%h exp=00", tx_data); end
    tick();
    rst = 1'b1; tx_ready = 1'b1;
    #1;
    vectors++; if (grant !== 4'b0000) begin errors++; $display("FAIL mid_post_idle got=%b exp=0000", grant); end
    tick();
    #1;
    vectors++; if (grant !== 4'b0001) begin errors++; $display("FAIL mid_first_winner got=%b exp=0001", grant); end
    vectors++; if (tx_data !== 8'h99) begin errors++; $display("FAIL mid_first_data got=%h exp=99", tx_data); end
    tick();
    req_valid = '0; tx_ready = 1'b0;
    tick();
  endtask

  task automatic test_owner_stall();
    do_reset();
    req_valid = 4'b0001; req_data = '0; req_data[7:0] = 8'h77; req_data[15:8] = 8'h88;
    req_last = 4'b0011; tx_ready = 1'b0;
    tick();
    #1;
    vectors++; if (grant !== 4'b0001) begin errors++; $display("FAIL stall_grant got=%b exp=0001", grant); end
    req_valid = 4'b0010; tx_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      vectors++; if (grant !== 4'b0001) begin errors++; $display("FAIL stall_hold c%0d got=%b exp=0001", c, grant); end
      vectors++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL stall_valid c%0d got=%b exp=0", c, tx_valid); end
      vectors++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL stall_ready c%0d got=%b exp=0001", c, req_ready); end
    end
    req_valid = 4'b0011;
    #1;
    vectors++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL stall_resume got=%b exp=1", tx_valid); end
    vectors++; if (tx_data !== 8'h77) begin errors++; $display("FAIL stall_data got=%h exp=77", tx_data); end
    tick();
    req_valid = 4'b0010;
    #1;
    vectors++; if (grant !== 4'b0000) begin errors++; $display("FAIL stall_release got=%b exp=0000", grant); end
    tick();
    #1;
    vectors++; if (grant !== 4'b0010) begin errors++; $display("FAIL stall_next got=%b exp=0010", grant); end
    vectors++; if (tx_data !== 8'h88) begin errors++; $display("FAIL stall_next_data got=%h exp=88", tx_data); end
    tick();
    req_valid = '0; tx_ready = 1'b0;
    tick();
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_packet_lock();
    test_reset_mid();
    test_owner_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
